// File: rtl/risc_rf_pkg.sv
// Shared defaults and reset-value helper for the RISC register file.
package risc_rf_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 3;
  localparam int unsigned DEF_RST_STEP = 32'h22;

  // Reset value of register idx; callers truncate to DATA_W (mod 2**DATA_W).
  function automatic logic [31:0] rst_val(input int unsigned idx,
                                          input int unsigned step,
                                          input bit          zero_r0);
    if (zero_r0 && idx == 0) return 32'h0;
    return 32'(idx * step);
  endfunction

endpackage

// File: rtl/risc_rf_scoreboard.sv
// Load scoreboard: per-register pending bits, pending count, issue/return
// error pulses and operand-ready lookup for both read ports.
module risc_rf_scoreboard
  import risc_rf_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_iss_vld,
  input  logic [ADDR_W-1:0] ld_iss_dst,
  input  logic              ld_ret_vld,
  input  logic [ADDR_W-1:0] ld_ret_dst,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              iss_err,
  output logic              ret_err,
  output logic              opnda_rdy_c,
  output logic              opndb_rdy_c
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iss_err_q, iss_err_d;
  logic             ret_err_q, ret_err_d;
  logic             iss_eff, ret_eff, cnt_inc, cnt_dec;

  // Next pending state; issue beats return on the same register, and the
  // counter follows the actual bit transitions so it always equals popcount.
  always_comb begin
    iss_eff   = ld_iss_vld && !(ZERO_R0 && ld_iss_dst == '0);
    ret_eff   = ld_ret_vld && !(ZERO_R0 && ld_ret_dst == '0);
    pending_d = pending_q;
    if (ret_eff) pending_d[ld_ret_dst] = 1'b0;
    if (iss_eff) pending_d[ld_iss_dst] = 1'b1;
    cnt_inc   = iss_eff && !pending_q[ld_iss_dst];
    cnt_dec   = ret_eff && pending_q[ld_ret_dst] &&
                !(iss_eff && ld_iss_dst == ld_ret_dst);
    cnt_d     = cnt_q;
    if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - CNT_W'(1);
    iss_err_d = iss_eff && pending_q[ld_iss_dst];
    ret_err_d = ret_eff && !pending_q[ld_ret_dst];
  end

  // Scoreboard state and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      iss_err_q <= 1'b0;
      ret_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      iss_err_q <= iss_err_d;
      ret_err_q <= ret_err_d;
    end
  end

  // Operand readiness; a same-cycle return resolves the hazard when bypassing.
  always_comb begin
    opnda_rdy_c = !pending_q[opnda_addr] ||
                  (BYPASS && ld_ret_vld && ld_ret_dst == opnda_addr);
    opndb_rdy_c = !pending_q[opndb_addr] ||
                  (BYPASS && ld_ret_vld && ld_ret_dst == opndb_addr);
    if (ZERO_R0 && opnda_addr == '0) opnda_rdy_c = 1'b1;
    if (ZERO_R0 && opndb_addr == '0) opndb_rdy_c = 1'b1;
  end

  assign pending_cnt = cnt_q;
  assign iss_err     = iss_err_q;
  assign ret_err     = ret_err_q;

endmodule

// File: rtl/risc_regfile_sb.sv
// Register file with dual write ports (ALU, load return), optional bypass,
// optional hard-wired r0 and a load scoreboard.
module risc_regfile_sb
  import risc_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RST_STEP = DEF_RST_STEP,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_R0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic [DATA_W-1:0] oprnd_a,
  output logic [DATA_W-1:0] oprnd_b,
  output logic              opnda_rdy,
  output logic              opndb_rdy,
  input  logic              reg_wr_vld,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] rslt,
  input  logic              ld_iss_vld,
  input  logic [ADDR_W-1:0] ld_iss_dst,
  input  logic              ld_ret_vld,
  input  logic [ADDR_W-1:0] ld_ret_dst,
  input  logic [DATA_W-1:0] dmdataout,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              wr_conflict,
  output logic              iss_err,
  output logic              ret_err
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              alu_we, ld_we, conflict_d, wr_conflict_q;

  // Write arbitration: ALU wins a same-address collision, load data dropped.
  always_comb begin
    alu_we     = reg_wr_vld && !(ZERO_R0 && dst == '0);
    conflict_d = alu_we && ld_ret_vld && ld_ret_dst == dst;
    ld_we      = ld_ret_vld && !(ZERO_R0 && ld_ret_dst == '0) && !conflict_d;
    regs_d     = regs_q;
    if (ld_we)  regs_d[ld_ret_dst] = dmdataout;
    if (alu_we) regs_d[dst]        = rslt;
  end

  // Data array and conflict pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= DATA_W'(rst_val(i, RST_STEP, ZERO_R0));
      end
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= conflict_d;
    end
  end

  // Read muxes: ALU bypass over load bypass over stored value.
  always_comb begin
    oprnd_a = regs_q[opnda_addr];
    oprnd_b = regs_q[opndb_addr];
    if (BYPASS) begin
      if (reg_wr_vld && dst == opnda_addr)             oprnd_a = rslt;
      else if (ld_ret_vld && ld_ret_dst == opnda_addr) oprnd_a = dmdataout;
      if (reg_wr_vld && dst == opndb_addr)             oprnd_b = rslt;
      else if (ld_ret_vld && ld_ret_dst == opndb_addr) oprnd_b = dmdataout;
    end
    if (ZERO_R0 && opnda_addr == '0) oprnd_a = '0;
    if (ZERO_R0 && opndb_addr == '0) oprnd_b = '0;
  end

  // Load scoreboard.
  risc_rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_iss_vld  (ld_iss_vld),
    .ld_iss_dst  (ld_iss_dst),
    .ld_ret_vld  (ld_ret_vld),
    .ld_ret_dst  (ld_ret_dst),
    .opnda_addr  (opnda_addr),
    .opndb_addr  (opndb_addr),
    .pending_cnt (pending_cnt),
    .iss_err     (iss_err),
    .ret_err     (ret_err),
    .opnda_rdy_c (opnda_rdy),
    .opndb_rdy_c (opndb_rdy)
  );

  assign wr_conflict = wr_conflict_q;

endmodule
